periph_bus_master: RTL and testbench
====================================

PERIPH_BUS_MASTER -- requirements
Module: periph_bus_master

Interface
REQ-001 SHALL have parameters: none; address and data widths fixed at 32 bits.
REQ-002 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: cmd_valid  in  1  command request.
REQ-005 SHALL have ports: cmd_ready  out  1  command accepted when high with cmd_valid.
REQ-006 SHALL have ports: cmd_op  in  2  00 READ, 01 WRITE, 10 RMW, 11 reserved.
REQ-007 SHALL have ports: cmd_addr  in  32  target register address.
REQ-008 SHALL have ports: cmd_data  in  32  write data / RMW insert data.
REQ-009 SHALL have ports: cmd_mask  in  32  RMW bit mask, 1 = take cmd_data bit.
REQ-010 SHALL have ports: rsp_valid  out  1  response available.
REQ-011 SHALL have ports: rsp_ready  in  1  response consumed when high with rsp_valid.
REQ-012 SHALL have ports: rsp_data  out  32  read value (READ/RMW: pre-modify value; WRITE: data written).
REQ-013 SHALL have ports: rsp_err  out  1  reserved opcode flag.
REQ-014 SHALL have ports: address  out  32  peripheral register address.
REQ-015 SHALL have ports: wr_en  out  1  peripheral write strobe.
REQ-016 SHALL have ports: rd_en  out  1  peripheral read strobe.
REQ-017 SHALL have ports: wr_data  out  32  peripheral write data.
REQ-018 SHALL have ports: rd_data  in  32  peripheral read data, valid combinationally while rd_en high.
REQ-019 SHALL have ports: busy  out  1  high in any state other than IDLE.

Function
REQ-020 SHALL implement FSM states IDLE, RD, WR, RESP; all outputs driven from flops.
REQ-021 SHALL assert cmd_ready only in IDLE; command fields latched on cmd_valid & cmd_ready.
REQ-022 SHALL transition IDLE->RD for READ/RMW, IDLE->WR for WRITE, IDLE->RESP for reserved op.
REQ-023 SHALL in RD drive rd_en=1, wr_en=0, address=latched addr for exactly one cycle, sampling rd_data at that cycle's closing edge.
REQ-024 SHALL transition RD->RESP for READ, RD->WR for RMW.
REQ-025 SHALL in WR drive wr_en=1, rd_en=0, address=latched addr for exactly one cycle; wr_data = cmd_data (WRITE) or (rd_sample & ~mask) | (cmd_data & mask) (RMW).
REQ-026 SHALL transition WR->RESP unconditionally.
REQ-027 SHALL hold rsp_valid=1 and rsp_data/rsp_err stable in RESP until rsp_ready=1, then return to IDLE.
REQ-028 SHALL drive rsp_err=1, rsp_data=0 for reserved opcode with no bus strobe.
REQ-029 SHALL never assert rd_en and wr_en in the same cycle.
REQ-030 SHALL drive address=0, wr_data=0, rd_en=0, wr_en=0 whenever not in RD or WR.
REQ-031 SHALL meet latency from acceptance edge N: READ rd_en in N+1, rsp_valid N+2; WRITE wr_en N+1, rsp_valid N+2; RMW rd_en N+1, wr_en N+2, rsp_valid N+3; reserved rsp_valid N+1.
REQ-032 SHALL ignore cmd_valid and all cmd_* inputs while not in IDLE; held command changes have no effect on in-flight operation.
REQ-033 SHALL ignore rsp_ready outside RESP.
REQ-034 SHALL not accept a new command in the cycle rsp_ready completes the response (one idle cycle between operations).

Reset
REQ-035 SHALL on rst=1, asynchronously force IDLE; cmd_ready=0 during reset, then 1 from first cycle after release; all other outputs 0.
REQ-036 SHALL on rst mid-operation abandon the in-flight command with no response and no further strobe.

Verification
REQ-037 SHALL cover WRITE addr 0x8 data 0x0000_0100 -> wr_en one cycle at N+1 with address 0x8, wr_data 0x100; rsp_valid N+2, rsp_data 0x100, rsp_err 0.
REQ-038 SHALL cover READ addr 0x4, rd_data model 0x1234_5678 -> rd_en one cycle at N+1; rsp_data 0x1234_5678 at N+2.
REQ-039 SHALL cover RMW addr 0x0, rd_data 0x0000_000F, mask 0x0000_0006, data 0x0000_0000 -> wr_data 0x0000_0009 at N+2; rsp_data 0x0000_000F.
REQ-040 SHALL cover reserved op 11 -> no strobes, rsp_valid N+1, rsp_err 1, rsp_data 0.
REQ-041 SHALL cover rsp_ready held low 5 cycles -> rsp_valid/rsp_data stable, cmd_ready 0, new cmd_valid ignored until handshake.
REQ-042 SHALL cover rst asserted during RMW RD cycle -> no wr_en, no rsp_valid, cmd_ready 1 after release.

Source files
------------

// File: rtl/periph_bus_master.sv
`default_nettype none
// ----------------------------------------------------------------------------
// periph_bus_master : single-outstanding READ/WRITE/RMW register bus master
// rev 1.0
// ----------------------------------------------------------------------------
module periph_bus_master (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_data,
  input  logic [31:0] cmd_mask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [31:0] address,
  output logic        wr_en,
  output logic        rd_en,
  output logic [31:0] wr_data,
  input  logic [31:0] rd_data,
  output logic        busy
);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_RMW   = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t      state;
  state_t      next_state;

  logic [1:0]  lat_op;
  logic [31:0] lat_addr;
  logic [31:0] lat_data;
  logic [31:0] lat_mask;
  logic [31:0] rd_sample;

  logic        accept;
  logic        cmd_ready_nx;
  logic        rsp_valid_nx;
  logic [31:0] rsp_data_nx;
  logic        rsp_err_nx;
  logic [31:0] address_nx;
  logic        wr_en_nx;
  logic        rd_en_nx;
  logic [31:0] wr_data_nx;
  logic        busy_nx;

  assign accept = (state == IDLE) && cmd_valid && cmd_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Every output is the registered image of its next-state value, so the
  // strobes line up with the state they belong to without combinational paths.
  always_comb begin
    next_state   = state;
    rsp_valid_nx = 1'b0;
    rsp_data_nx  = 32'd0;
    rsp_err_nx   = 1'b0;
    address_nx   = 32'd0;
    wr_en_nx     = 1'b0;
    rd_en_nx     = 1'b0;
    wr_data_nx   = 32'd0;

    case (state)
      IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_READ, OP_RMW: begin
              next_state = RD;
              rd_en_nx   = 1'b1;
              address_nx = cmd_addr;
            end
            OP_WRITE: begin
              next_state = WR;
              wr_en_nx   = 1'b1;
              address_nx = cmd_addr;
              wr_data_nx = cmd_data;
            end
            default: begin
              next_state   = RESP;
              rsp_valid_nx = 1'b1;
              rsp_err_nx   = 1'b1;
            end
          endcase
        end
      end
      RD: begin
        if (lat_op == OP_RMW) begin
          next_state = WR;
          wr_en_nx   = 1'b1;
          address_nx = lat_addr;
          wr_data_nx = (rd_data & ~lat_mask) | (lat_data & lat_mask);
        end else begin
          next_state   = RESP;
          rsp_valid_nx = 1'b1;
          rsp_data_nx  = rd_data;
        end
      end
      WR: begin
        next_state   = RESP;
        rsp_valid_nx = 1'b1;
        rsp_data_nx  = (lat_op == OP_RMW) ? rd_sample : lat_data;
      end
      RESP: begin
        if (rsp_ready) begin
          next_state = IDLE;
        end else begin
          rsp_valid_nx = 1'b1;
          rsp_data_nx  = rsp_data;
          rsp_err_nx   = rsp_err;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase

    cmd_ready_nx = (next_state == IDLE);
    busy_nx      = (next_state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= 32'd0;
      rsp_err   <= 1'b0;
      address   <= 32'd0;
      wr_en     <= 1'b0;
      rd_en     <= 1'b0;
      wr_data   <= 32'd0;
      busy      <= 1'b0;
      lat_op    <= 2'd0;
      lat_addr  <= 32'd0;
      lat_data  <= 32'd0;
      lat_mask  <= 32'd0;
      rd_sample <= 32'd0;
    end else begin
      cmd_ready <= cmd_ready_nx;
      rsp_valid <= rsp_valid_nx;
      rsp_data  <= rsp_data_nx;
      rsp_err   <= rsp_err_nx;
      address   <= address_nx;
      wr_en     <= wr_en_nx;
      rd_en     <= rd_en_nx;
      wr_data   <= wr_data_nx;
      busy      <= busy_nx;
      if (accept) begin
        lat_op   <= cmd_op;
        lat_addr <= cmd_addr;
        lat_data <= cmd_data;
        lat_mask <= cmd_mask;
      end
      if (state == RD) begin
        rd_sample <= rd_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_periph_bus_master.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_periph_bus_master : directed and randomized checks against a register model
// rev 1.0
// ----------------------------------------------------------------------------
module tb_periph_bus_master;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_data;
  logic [31:0] cmd_mask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [31:0] address;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  // bad bits: 0 rd+wr overlap, 1 bus not idle, 2 cmd_ready in flight,
  // 3 busy low in flight, 4 response unstable, 5 timeout, 6 post-handshake state
  typedef struct packed {
    logic [3:0]  rd_cnt;
    logic [4:0]  rd_at;
    logic [31:0] rd_addr;
    logic [3:0]  wr_cnt;
    logic [4:0]  wr_at;
    logic [31:0] wr_addr;
    logic [31:0] wr_dat;
    logic [4:0]  rsp_at;
    logic [31:0] rsp_dat;
    logic        rsp_e;
    logic [4:0]  rsp_cyc;
    logic [6:0]  bad;
  } obs_t;

  // peripheral register file (16 words) and the bench's own expected copy
  logic [31:0] per_mem [16];
  logic [31:0] model_mem [16];
  logic        load_en;
  logic [3:0]  load_idx;
  logic [31:0] load_val;

  periph_bus_master dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .cmd_mask  (cmd_mask),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .address   (address),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rd_data = rd_en ? per_mem[address[5:2]] : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (load_en) per_mem[load_idx] <= load_val;
    else if (wr_en) per_mem[address[5:2]] <= wr_data;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic load_mem(input int idx, input logic [31:0] v);
    model_mem[idx] = v;
    @(negedge clk);
    load_en  = 1'b1;
    load_idx = 4'(idx);
    load_val = v;
    @(negedge clk);
    load_en  = 1'b0;
  endtask

  task automatic scramble_cmd();
    cmd_op   = 2'($urandom);
    cmd_addr = $urandom;
    cmd_data = $urandom;
    cmd_mask = $urandom;
  endtask

  // Issues one command and records what the bus and response ports did,
  // counting cycles from the acceptance edge.
  task automatic run_cmd(input logic [1:0] op, input logic [31:0] addr,
                         input logic [31:0] data, input logic [31:0] mask,
                         input int hold, input bit noise, output obs_t o);
    int  k;
    int  seen;
    bit  done;
    o = '0;
    k = 0;
    while (!cmd_ready && k < 10) begin
      @(negedge clk);
      k++;
    end
    if (!cmd_ready) begin
      o.bad[5] = 1'b1;
      return;
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
    cmd_mask  = mask;
    @(posedge clk);
    #1;
    cmd_valid = noise;
    scramble_cmd();
    seen = 0;
    done = 1'b0;
    k    = 0;
    while (!done) begin
      @(negedge clk);
      k++;
      if (k > 30) begin
        o.bad[5] = 1'b1;
        break;
      end
      if (rd_en && wr_en) o.bad[0] = 1'b1;
      if (rd_en) begin
        if (o.rd_cnt == 4'd0) begin
          o.rd_at   = 5'(k);
          o.rd_addr = address;
        end
        o.rd_cnt = o.rd_cnt + 4'd1;
      end
      if (wr_en) begin
        if (o.wr_cnt == 4'd0) begin
          o.wr_at   = 5'(k);
          o.wr_addr = address;
          o.wr_dat  = wr_data;
        end
        o.wr_cnt = o.wr_cnt + 4'd1;
      end
      if (!rd_en && !wr_en && (address != 32'd0 || wr_data != 32'd0)) o.bad[1] = 1'b1;
      if (cmd_ready) o.bad[2] = 1'b1;
      if (!busy) o.bad[3] = 1'b1;
      if (rsp_valid) begin
        seen++;
        if (seen == 1) begin
          o.rsp_at  = 5'(k);
          o.rsp_dat = rsp_data;
          o.rsp_e   = rsp_err;
        end else if (rsp_data !== o.rsp_dat || rsp_err !== o.rsp_e) begin
          o.bad[4] = 1'b1;
        end
        if (seen > hold) begin
          rsp_ready = 1'b1;
          @(posedge clk);
          #1;
          rsp_ready = 1'b0;
          cmd_valid = 1'b0;
          done      = 1'b1;
        end else begin
          rsp_ready = 1'b0;
        end
      end else begin
        rsp_ready = noise ? 1'($urandom) : 1'b0;
      end
      if (noise && !done) scramble_cmd();
    end
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    o.rsp_cyc = 5'(seen);
    if (done) begin
      @(negedge clk);
      if (!cmd_ready || busy || rsp_valid || rd_en || wr_en) o.bad[6] = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    load_en   = 1'b0;
    load_idx  = 4'd0;
    load_val  = 32'd0;
    scramble_cmd();
    for (int i = 0; i < 16; i++) load_mem(i, $urandom);
    n_checks++;
    if ({cmd_ready, rsp_valid, rsp_data, rsp_err, address, wr_en, rd_en, wr_data, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b rv=%b rd=%h re=%b a=%h we=%b re=%b wd=%h busy=%b, expected all 0",
               cmd_ready, rsp_valid, rsp_data, rsp_err, address, wr_en, rd_en, wr_data, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got cmd_ready=%b busy=%b, expected 1/0", cmd_ready, busy);
    end
  endtask

  task automatic test_write();
    obs_t o, e;
    run_cmd(2'b01, 32'h8, 32'h0000_0100, $urandom, 0, 1'b0, o);
    model_mem[2] = 32'h0000_0100;
    e = '0;
    e.wr_cnt = 4'd1; e.wr_at = 5'd1; e.wr_addr = 32'h8; e.wr_dat = 32'h100;
    e.rsp_at = 5'd2; e.rsp_dat = 32'h100; e.rsp_cyc = 5'd1;
    n_checks++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL write_basic: got %h expected %h", o, e);
    end
  endtask

  task automatic test_read();
    obs_t o, e;
    load_mem(1, 32'h1234_5678);
    run_cmd(2'b00, 32'h4, $urandom, $urandom, 0, 1'b0, o);
    e = '0;
    e.rd_cnt = 4'd1; e.rd_at = 5'd1; e.rd_addr = 32'h4;
    e.rsp_at = 5'd2; e.rsp_dat = 32'h1234_5678; e.rsp_cyc = 5'd1;
    n_checks++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL read_basic: got %h expected %h", o, e);
    end
  endtask

  task automatic test_rmw();
    obs_t o, e;
    load_mem(0, 32'h0000_000F);
    run_cmd(2'b10, 32'h0, 32'h0, 32'h0000_0006, 0, 1'b0, o);
    model_mem[0] = 32'h0000_0009;
    e = '0;
    e.rd_cnt = 4'd1; e.rd_at = 5'd1; e.rd_addr = 32'h0;
    e.wr_cnt = 4'd1; e.wr_at = 5'd2; e.wr_addr = 32'h0; e.wr_dat = 32'h9;
    e.rsp_at = 5'd3; e.rsp_dat = 32'hF; e.rsp_cyc = 5'd1;
    n_checks++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL rmw_basic: got %h expected %h", o, e);
    end
    n_checks++;
    if (o.wr_dat !== 32'h9) begin
      n_fail++;
      $display("FAIL rmw_wr_data: got %h expected 00000009", o.wr_dat);
    end
  endtask

  task automatic test_reserved();
    obs_t o, e;
    run_cmd(2'b11, $urandom, $urandom, $urandom, 0, 1'b1, o);
    e = '0;
    e.rsp_at = 5'd1; e.rsp_e = 1'b1; e.rsp_cyc = 5'd1;
    n_checks++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL reserved_op: got %h expected %h", o, e);
    end
  endtask

  task automatic test_backpressure();
    obs_t o, e;
    run_cmd(2'b00, 32'h4, $urandom, $urandom, 5, 1'b1, o);
    e = '0;
    e.rd_cnt = 4'd1; e.rd_at = 5'd1; e.rd_addr = 32'h4;
    e.rsp_at = 5'd2; e.rsp_dat = model_mem[1]; e.rsp_cyc = 5'd6;
    n_checks++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL backpressure: got %h expected %h", o, e);
    end
    n_checks++;
    if (o.rsp_cyc !== 5'd6 || o.bad !== 7'd0) begin
      n_fail++;
      $display("FAIL backpressure_hold: got cycles=%0d bad=%b expected 6/0000000", o.rsp_cyc, o.bad);
    end
  endtask

  task automatic test_reset_mid_rmw();
    bit bad;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'b10;
    cmd_addr  = 32'h0;
    cmd_data  = 32'hFFFF_FFFF;
    cmd_mask  = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rd_en !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_rmw_rd: got rd_en=%b expected 1", rd_en);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({rd_en, wr_en, rsp_valid, cmd_ready, busy, address} !== '0) begin
      n_fail++;
      $display("FAIL rst_async: got rd=%b wr=%b rv=%b rdy=%b busy=%b a=%h expected all 0",
               rd_en, wr_en, rsp_valid, cmd_ready, busy, address);
    end
    @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (wr_en || rd_en || rsp_valid || busy || !cmd_ready) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL rst_rmw_abandon: got activity or cmd_ready low after release, expected idle with cmd_ready=1");
    end
    n_checks++;
    if (per_mem[0] !== model_mem[0]) begin
      n_fail++;
      $display("FAIL rst_rmw_mem: got reg0=%h expected %h", per_mem[0], model_mem[0]);
    end
  endtask

  task automatic test_random();
    obs_t        o, e;
    logic [1:0]  op;
    logic [31:0] addr, data, mask, old;
    int          idx, hold;
    bit          noise;
    for (int t = 0; t < 40; t++) begin
      op    = 2'($urandom);
      addr  = $urandom;
      data  = $urandom;
      mask  = $urandom;
      hold  = int'($urandom_range(0, 3));
      noise = 1'($urandom);
      idx   = int'(addr[5:2]);
      old   = model_mem[idx];
      e = '0;
      e.rsp_cyc = 5'(hold + 1);
      case (op)
        2'b00: begin
          e.rd_cnt = 4'd1; e.rd_at = 5'd1; e.rd_addr = addr;
          e.rsp_at = 5'd2; e.rsp_dat = old;
        end
        2'b01: begin
          e.wr_cnt = 4'd1; e.wr_at = 5'd1; e.wr_addr = addr; e.wr_dat = data;
          e.rsp_at = 5'd2; e.rsp_dat = data;
          model_mem[idx] = data;
        end
        2'b10: begin
          e.rd_cnt = 4'd1; e.rd_at = 5'd1; e.rd_addr = addr;
          e.wr_cnt = 4'd1; e.wr_at = 5'd2; e.wr_addr = addr;
          e.wr_dat = (old & ~mask) | (data & mask);
          e.rsp_at = 5'd3; e.rsp_dat = old;
          model_mem[idx] = e.wr_dat;
        end
        default: begin
          e.rsp_at = 5'd1; e.rsp_e = 1'b1;
        end
      endcase
      run_cmd(op, addr, data, mask, hold, noise, o);
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL random_%0d op=%0d: got %h expected %h", t, op, o, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_rmw();
    test_reserved();
    test_backpressure();
    test_reset_mid_rmw();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
